// File: rtl/log2_pkg.sv
// Shared types for the log2 sequencer: widths, FSM states, result packing.
// Optional RUN timeout is enabled with LOG2_CTRL_TIMEOUT_EN.
package log2_pkg;

  localparam int IN_W    = 8;
  localparam int CHAR_W  = 3;
  localparam int MANT_W  = 5;
  localparam int TIMEOUT = 15;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } log2_state_t;

  typedef struct packed {
    logic [CHAR_W-1:0] chr;
    logic [MANT_W-1:0] mant;
  } log2_result_t;

endpackage

// File: rtl/log2_norm.sv
// Leading-one detector and left shifter: x -> characteristic k and 1.7 operand.
// Zero input yields k=0, m=0; the controller never loads that case.
module log2_norm
  import log2_pkg::*;
(
  input  logic [IN_W-1:0]   x,
  output logic [CHAR_W-1:0] k,
  output logic [IN_W-1:0]   m
);

  localparam logic [CHAR_W-1:0] KMAX = CHAR_W'(IN_W - 1);

  always_comb begin
    k = '0;
    for (int i = 0; i < IN_W; i++) begin
      if (x[i]) k = CHAR_W'(i);
    end
    m = x << (KMAX - k);
  end

endmodule

// File: rtl/log2_ctrl.sv
// Sequencer for the iterative log2 mantissa unit (normalise, load, wait, return).
// Define LOG2_CTRL_TIMEOUT_EN to bound the RUN wait to TIMEOUT cycles.
module log2_ctrl
  import log2_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_x,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IN_W-1:0]   out_result,
  output logic              out_err,
  output logic              mu_load,
  output logic [IN_W-1:0]   mu_m,
  input  logic [MANT_W-1:0] mu_mantissa,
  input  logic              mu_ready
);

  log2_state_t       state;
  log2_state_t       state_n;
  logic [CHAR_W-1:0] norm_k;
  logic [IN_W-1:0]   norm_m;
  logic [CHAR_W-1:0] chr_q;
  logic [IN_W-1:0]   m_q;
  log2_result_t      res_q;
  logic              err_q;
  logic              x_zero;
  logic              expired;

  log2_norm u_norm (
    .x (in_x),
    .k (norm_k),
    .m (norm_m)
  );

  assign x_zero = (in_x == '0);

`ifdef LOG2_CTRL_TIMEOUT_EN
  logic [3:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (state != RUN) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 4'd1;
    end
  end

  assign expired = (cnt == 4'(TIMEOUT - 1));
`else
  assign expired = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (in_valid) state_n = x_zero ? DONE : LOAD;
      LOAD: state_n = RUN;
      RUN:  if (mu_ready || expired) state_n = DONE;
      DONE: if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // mu_ready is only honoured in RUN, so a stale pulse from an abandoned op is harmless
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q   <= '0;
      chr_q <= '0;
      res_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state == IDLE && in_valid) begin
        if (x_zero) begin
          res_q <= '0;
          err_q <= 1'b1;
        end else begin
          m_q   <= norm_m;
          chr_q <= norm_k;
        end
      end
      if (state == RUN) begin
        if (mu_ready) begin
          res_q <= '{chr: chr_q, mant: mu_mantissa};
          err_q <= 1'b0;
        end else if (expired) begin
          res_q <= '0;
          err_q <= 1'b1;
        end
      end
    end
  end

  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign mu_load    = (state == LOAD);
  assign mu_m       = m_q;
  assign out_result = res_q;
  assign out_err    = err_q;

endmodule

// File: tb/tb_log2_ctrl.sv
// Scoreboard bench for log2_ctrl with a delayed-ready mantissa stub.
// Define LOG2_CTRL_TIMEOUT_EN to exercise the timeout path.
module tb_log2_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_x = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_result;
  logic       out_err;
  logic       mu_load;
  logic [7:0] mu_m;
  logic [4:0] mu_mantissa;
  logic       mu_ready;

  int n_chk = 0;
  int n_fail = 0;

  int         stub_n = 1;
  logic [4:0] stub_mant = '0;
  logic       stub_never = 1'b0;
  logic       st_act = 1'b0;
  int         st_cnt = 0;

  int mq[$];
  int sb[$];

  always #5 clk = ~clk;

  log2_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_x        (in_x),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_err     (out_err),
    .mu_load     (mu_load),
    .mu_m        (mu_m),
    .mu_mantissa (mu_mantissa),
    .mu_ready    (mu_ready)
  );

  // stub: ready for one cycle, stub_n cycles after the load pulse
  always @(posedge clk) begin
    if (mu_load) begin
      st_act <= 1'b1;
      st_cnt <= stub_n - 1;
    end else if (st_act) begin
      if (st_cnt == 0) st_act <= 1'b0;
      else             st_cnt <= st_cnt - 1;
    end
  end

  assign mu_ready    = st_act && (st_cnt == 0) && !stub_never;
  assign mu_mantissa = stub_mant;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int ref_k(input int x);
    int k = 0;
    while ((1 << (k + 1)) <= x) k++;
    return k;
  endfunction

  function automatic int ref_m(input int x);
    return (x << (7 - ref_k(x))) & 255;
  endfunction

  // {err, result} packed as err*256 + result
  function automatic int ref_out(input int x, input int mant, input bit tmo);
    if (x == 0 || tmo) return 256;
    return ref_k(x) * 32 + mant;
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (mu_load) begin
        if (mq.size() == 0) chk("unexpected_mu_load", 1, 0);
        else                chk("mu_m_at_load", int'(mu_m), mq.pop_front());
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("unexpected_result", 1, 0);
        else chk("result_err", int'({out_err, out_result}), sb.pop_front());
      end
    end
  end

  task automatic run_one(input int x, input int n, input int mant,
                         input int hold, input bit tmo);
    int lat;
    int exp;
    int exp_lat;
    bit seen;
    exp = ref_out(x, mant, tmo);
    exp_lat = (x == 0) ? 1 : (tmo ? 17 : n + 2);
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (in_ready) seen = 1;
    end
    if (!seen) chk("wait_in_ready", 0, 1);
    @(posedge clk); #1;
    in_valid   = 1'b1;
    in_x       = 8'(x);
    stub_n     = n;
    stub_mant  = 5'(mant);
    stub_never = tmo;
    if (x != 0) mq.push_back(ref_m(x));
    sb.push_back(exp);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat  = 0;
    seen = 0;
    while (!seen && lat < 300) begin
      @(negedge clk);
      lat++;
      if (out_valid) seen = 1;
    end
    chk("out_valid_latency", lat, exp_lat);
    for (int h = 0; h < hold; h++) begin
      chk("held_in_ready", int'(in_ready), 0);
      chk("held_result", int'({out_err, out_result}), exp);
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_x     = 8'($urandom_range(1, 255));
      @(negedge clk);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready  = 1'b0;
    stub_never = 1'b0;
    @(negedge clk);
    chk("idle_after_handshake", int'({in_ready, out_valid}), 2);
  endtask

  task automatic reset_checks();
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_result", int'(out_result), 0);
    chk("rst_out_err", int'(out_err), 0);
    chk("rst_mu_load", int'(mu_load), 0);
    chk("rst_mu_m", int'(mu_m), 0);
  endtask

  initial begin
    int x;
    bit any_valid;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_checks();
    @(posedge clk); #1;
    reset = 1'b0;

    run_one(8, 5, 0, 0, 0);
    run_one(3, 3, 5'b10010, 1, 0);
    run_one(0, 2, 7, 2, 0);
    run_one(200, 4, 5'b01101, 4, 0);
    run_one(1, 1, 5'b11111, 0, 0);
    run_one(255, 2, 5'b10101, 0, 0);
    run_one(128, 6, 5'b00011, 0, 0);

    for (int i = 0; i < 20; i++) begin
      x = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
      run_one(x, int'($urandom_range(1, 6)), int'($urandom_range(0, 31)),
              int'($urandom_range(0, 3)), 0);
    end

    // reset during RUN; the stub's late ready must not revive the op
    @(posedge clk); #1;
    in_valid  = 1'b1;
    in_x      = 8'd37;
    stub_n    = 12;
    stub_mant = 5'd9;
    mq.push_back(ref_m(37));
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    reset_checks();
    @(posedge clk); #1;
    reset = 1'b0;
    any_valid = 0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid) any_valid = 1;
    end
    chk("no_valid_after_reset", int'(any_valid), 0);
    run_one(6, 2, 5'b00110, 0, 0);

`ifdef LOG2_CTRL_TIMEOUT_EN
    run_one(77, 1, 5'd3, 1, 1);
`else
    @(posedge clk); #1;
    in_valid   = 1'b1;
    in_x       = 8'd5;
    stub_never = 1'b1;
    mq.push_back(ref_m(5));
    @(posedge clk); #1;
    in_valid = 1'b0;
    any_valid = 0;
    repeat (100) begin
      @(negedge clk);
      if (out_valid) any_valid = 1;
    end
    chk("no_timeout_wait", int'(any_valid), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    stub_never = 1'b0;
`endif

    run_one(42, 3, 5'b01010, 0, 0);
    chk("scoreboard_drained", sb.size() + mq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
